// File: rtl/serial_tx_if.sv
// Handshake and line bundle between an upstream word source and serial_tx.
// The master side drives tick, start and data; the transmitter is the slave.
interface serial_tx_if #(
  parameter int DATA_BIT = 8
);
  logic                tick_i;
  logic                tx_start_i;
  logic [DATA_BIT-1:0] din_i;
  logic                tx_o;
  logic                busy_o;
  logic                tx_done_tick_o;

  modport master (
    output tick_i, tx_start_i, din_i,
    input  tx_o, busy_o, tx_done_tick_o
  );

  modport slave (
    input  tick_i, tx_start_i, din_i,
    output tx_o, busy_o, tx_done_tick_o
  );
endinterface

// File: rtl/serial_tx.sv
// Tick-paced serial transmitter: start bit, DATA_BIT data bits LSB first,
// then an SB_TICK-long stop period. All outputs come straight from flops.
module serial_tx #(
  parameter int DATA_BIT   = 8,
  parameter int OVERSAMPLE = 16,
  parameter int SB_TICK    = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  serial_tx_if.slave sif
);

  localparam int S_MAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
  localparam int S_W   = $clog2(S_MAX);
  localparam int N_W   = (DATA_BIT > 1) ? $clog2(DATA_BIT) : 1;

  localparam logic [S_W-1:0] S_ZERO    = S_W'(0);
  localparam logic [S_W-1:0] S_ONE     = S_W'(1);
  localparam logic [S_W-1:0] S_OS_LAST = S_W'(OVERSAMPLE - 1);
  localparam logic [S_W-1:0] S_SB_LAST = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0] N_ZERO    = N_W'(0);
  localparam logic [N_W-1:0] N_ONE     = N_W'(1);
  localparam logic [N_W-1:0] N_LAST    = N_W'(DATA_BIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t              state_r;
  logic [S_W-1:0]      s_r;
  logic [N_W-1:0]      n_r;
  logic [DATA_BIT-1:0] b_r;
  logic [DATA_BIT-1:0] b_shift_s;
  logic                tx_r;
  logic                busy_r;
  logic                done_r;

  // Next data bit to present once the current one has been held long enough.
  assign b_shift_s = b_r >> 1'b1;

  // Frame sequencer; tx_r is loaded with the line value of the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      s_r     <= S_ZERO;
      n_r     <= N_ZERO;
      b_r     <= '0;
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (sif.tx_start_i) begin
            b_r     <= sif.din_i;
            s_r     <= S_ZERO;
            n_r     <= N_ZERO;
            tx_r    <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= ST_START;
          end else begin
            tx_r   <= 1'b1;
            busy_r <= 1'b0;
          end
        end
        ST_START: begin
          if (sif.tick_i) begin
            if (s_r == S_OS_LAST) begin
              s_r     <= S_ZERO;
              n_r     <= N_ZERO;
              tx_r    <= b_r[0];
              state_r <= ST_DATA;
            end else begin
              s_r <= s_r + S_ONE;
            end
          end
        end
        ST_DATA: begin
          if (sif.tick_i) begin
            if (s_r == S_OS_LAST) begin
              b_r <= b_shift_s;
              s_r <= S_ZERO;
              if (n_r == N_LAST) begin
                n_r     <= N_ZERO;
                tx_r    <= 1'b1;
                state_r <= ST_STOP;
              end else begin
                n_r  <= n_r + N_ONE;
                tx_r <= b_shift_s[0];
              end
            end else begin
              s_r <= s_r + S_ONE;
            end
          end
        end
        ST_STOP: begin
          if (sif.tick_i) begin
            if (s_r == S_SB_LAST) begin
              s_r     <= S_ZERO;
              n_r     <= N_ZERO;
              tx_r    <= 1'b1;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              state_r <= ST_IDLE;
            end else begin
              s_r <= s_r + S_ONE;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          s_r     <= S_ZERO;
          n_r     <= N_ZERO;
          tx_r    <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign sif.tx_o           = tx_r;
  assign sif.busy_o         = busy_r;
  assign sif.tx_done_tick_o = done_r;

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx: tick-count reference model plus
// table-driven frames and hand-written corner-case sequences.
module tb_serial_tx;

  localparam int FRAME_LEN = 160;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       tick   = 1'b0;
  logic       start1 = 1'b0;
  logic       start2 = 1'b0;
  logic [7:0] din1   = 8'h00;
  logic [6:0] din2   = 7'h00;

  serial_tx_if #(.DATA_BIT(8)) if1 ();
  serial_tx_if #(.DATA_BIT(7)) if2 ();

  assign if1.tick_i     = tick;
  assign if1.tx_start_i = start1;
  assign if1.din_i      = din1;
  assign if2.tick_i     = tick;
  assign if2.tx_start_i = start2;
  assign if2.din_i      = din2;

  serial_tx #(.DATA_BIT(8), .OVERSAMPLE(16), .SB_TICK(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .sif(if1)
  );
  serial_tx #(.DATA_BIT(7), .OVERSAMPLE(16), .SB_TICK(32)) dut2 (
    .clk(clk), .rst_n(rst_n), .sif(if2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: line value after k counted ticks of a frame carrying w.
  function automatic logic line_at(input logic [7:0] w, input int k);
    int slot;
    slot = k / 16;
    if (slot == 0) return 1'b0;
    else if (slot <= 8) return w[slot-1];
    else return 1'b1;
  endfunction

  logic       m_active, m_tx, m_done;
  int         m_ticks;
  logic [7:0] m_word;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0; m_tx <= 1'b1; m_done <= 1'b0; m_ticks <= 0; m_word <= 8'h00;
    end else if (!m_active) begin
      m_done <= 1'b0;
      if (start1) begin
        m_active <= 1'b1; m_word <= din1; m_ticks <= 0; m_tx <= 1'b0;
      end else begin
        m_tx <= 1'b1;
      end
    end else begin
      m_done <= 1'b0;
      if (tick) begin
        if (m_ticks + 1 == FRAME_LEN) begin
          m_active <= 1'b0; m_done <= 1'b1; m_tx <= 1'b1;
        end else begin
          m_ticks <= m_ticks + 1;
          m_tx    <= line_at(m_word, m_ticks + 1);
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("mdl_tx",   32'(if1.tx_o),           32'(m_tx));
    chk("mdl_busy", 32'(if1.busy_o),         32'(m_active));
    chk("mdl_done", 32'(if1.tx_done_tick_o), 32'(m_done));
  end

  int cyc = 0, tick_total = 0, base = 0, busy_cnt = 0, tphase = 0;
  bit tick_en = 1'b1;

  task automatic step();
    @(posedge clk);
    if (tick) tick_total++;
    #2;
    cyc++;
    if (if1.busy_o === 1'b1) busy_cnt++;
    if (tick_en) begin
      tphase = (tphase + 1) % 4;
      tick   = (tphase == 0);
    end else begin
      tick = 1'b0;
    end
  endtask

  task automatic accept_now(input logic [7:0] d);
    start1   = 1'b1;
    din1     = d;
    busy_cnt = 0;
    step();
    base   = tick_total;
    start1 = 1'b0;
    din1   = 8'($urandom);
    chk("accept_low",  32'(if1.tx_o),   32'd0);
    chk("accept_busy", 32'(if1.busy_o), 32'd1);
  endtask

  task automatic start_frame(input logic [7:0] d);
    int g;
    g = 0;
    while (tick !== 1'b1 && g < 8) begin step(); g++; end
    if (g >= 8) begin
      checks++; errors++;
      $display("FAIL align_timeout: no tick seen within %0d clk", g);
    end
    accept_now(d);
  endtask

  task automatic watch_frame(input logic [9:0] exp, input int stop_k, input int inj_k,
                             output int done_cyc);
    int  k, nk, guard;
    bit  injected;
    k = 0; guard = 0; injected = 1'b0; done_cyc = 0;
    while (k < stop_k && guard < 4000) begin
      step();
      guard++;
      nk = tick_total - base;
      if (inj_k >= 0 && nk >= inj_k && !injected) begin
        start1 = 1'b1; din1 = 8'h3C; injected = 1'b1;
      end else begin
        start1 = 1'b0;
      end
      if (nk != k) begin
        k = nk;
        if (k % 16 == 8 && k < FRAME_LEN) chk("slot_bit", 32'(if1.tx_o), 32'(exp[k/16]));
      end
    end
    start1 = 1'b0;
    if (guard >= 4000) begin
      checks++; errors++;
      $display("FAIL watch_timeout: reached %0d ticks, required %0d", k, stop_k);
    end else if (stop_k == FRAME_LEN) begin
      done_cyc = cyc;
      chk("done_pulse", 32'(if1.tx_done_tick_o), 32'd1);
      chk("done_idle",  32'(if1.busy_o),         32'd0);
      chk("done_line",  32'(if1.tx_o),           32'd1);
    end
  endtask

  typedef struct {
    logic [7:0] din;
    logic [9:0] slots;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int         dc, dc1, dc2, k, guard;
    logic [7:0] d;
    logic       exp7 [8];

    vecs[0] = '{din: 8'hA5, slots: 10'b1101001010};
    vecs[1] = '{din: 8'h00, slots: 10'b1000000000};
    vecs[2] = '{din: 8'hFF, slots: 10'b1111111110};
    vecs[3] = '{din: 8'h81, slots: 10'b1100000010};

    repeat (3) step();
    chk("rst_tx",   32'(if1.tx_o),           32'd1);
    chk("rst_busy", 32'(if1.busy_o),         32'd0);
    chk("rst_done", 32'(if1.tx_done_tick_o), 32'd0);
    chk("rst_tx2",  32'(if2.tx_o),           32'd1);
    rst_n = 1'b1;
    repeat (4) step();

    // Table frames, tick-aligned acceptance so busy spans exactly 640 clk.
    for (int i = 0; i < 4; i++) begin
      start_frame(vecs[i].din);
      watch_frame(vecs[i].slots, FRAME_LEN, -1, dc);
      chk("busy_640", 32'(busy_cnt), 32'd640);
      repeat (5) step();
    end

    // Back-to-back: second start raised in the done cycle.
    start_frame(8'h00);
    watch_frame(10'b1000000000, FRAME_LEN, -1, dc1);
    accept_now(8'hFF);
    watch_frame(10'b1111111110, FRAME_LEN, -1, dc2);
    chk("b2b_spacing", 32'(dc2 - dc1), 32'd640);
    repeat (5) step();

    // Start pulse during a frame must be ignored.
    start_frame(8'h81);
    watch_frame(10'b1100000010, FRAME_LEN, 50, dc);
    repeat (40) step();
    chk("ign_no_frame", 32'(if1.busy_o), 32'd0);

    // Asynchronous reset during data bit 3.
    start_frame(8'hC3);
    watch_frame(10'b1110000110, 72, -1, dc);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_tx",   32'(if1.tx_o),           32'd1);
    chk("arst_busy", 32'(if1.busy_o),         32'd0);
    chk("arst_done", 32'(if1.tx_done_tick_o), 32'd0);
    repeat (3) step();
    chk("arst_hold_done", 32'(if1.tx_done_tick_o), 32'd0);
    rst_n = 1'b1;
    repeat (3) step();
    start_frame(8'hA5);
    watch_frame(10'b1101001010, FRAME_LEN, -1, dc);
    repeat (5) step();

    // Ticks withheld after acceptance: everything must freeze.
    start_frame(8'h96);
    tick_en = 1'b0;
    tick    = 1'b0;
    repeat (1000) step();
    chk("stall_tx",    32'(if1.tx_o),   32'd0);
    chk("stall_busy",  32'(if1.busy_o), 32'd1);
    chk("stall_ticks", 32'(tick_total - base), 32'd0);
    tick_en = 1'b1;
    watch_frame(10'b1100101100, FRAME_LEN, -1, dc);
    repeat (5) step();

    // Randomized frames with stray start pulses, checked by the model.
    repeat (6) begin
      d = 8'($urandom);
      repeat ($urandom_range(0, 7)) step();
      if ($urandom % 2 == 0) start_frame(d);
      else accept_now(d);
      watch_frame({1'b1, d, 1'b0}, FRAME_LEN, int'($urandom_range(1, 150)), dc);
    end
    repeat (5) step();

    // Seven data bits with a two-bit stop period.
    exp7 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    guard = 0;
    while (tick !== 1'b1 && guard < 8) begin step(); guard++; end
    start2 = 1'b1;
    din2   = 7'h55;
    step();
    base   = tick_total;
    start2 = 1'b0;
    din2   = 7'h2A;
    k      = 0;
    guard  = 0;
    while (k < FRAME_LEN && guard < 4000) begin
      step();
      guard++;
      if (tick_total - base != k) begin
        k = tick_total - base;
        if (k % 16 == 8 && k < 128) chk("p7_bit", 32'(if2.tx_o), 32'(exp7[k/16]));
        if (k == 152) begin
          chk("p7_stop_line", 32'(if2.tx_o),           32'd1);
          chk("p7_stop_busy", 32'(if2.busy_o),         32'd1);
          chk("p7_no_early",  32'(if2.tx_done_tick_o), 32'd0);
        end
      end
    end
    if (guard >= 4000) begin
      checks++; errors++;
      $display("FAIL p7_timeout: reached %0d ticks, required %0d", k, FRAME_LEN);
    end else begin
      chk("p7_done", 32'(if2.tx_done_tick_o), 32'd1);
      chk("p7_idle", 32'(if2.busy_o),         32'd0);
    end
    step();
    chk("p7_done_once", 32'(if2.tx_done_tick_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
Tick-paced serial transmitter that sits directly downstream of the mod-M baud/tick counter. It consumes the counter's one-cycle max_tick pulse as its oversampling tick. It serializes a parallel word into a start bit, DATA_BIT data bits (LSB first) and a stop period on a single output line. Upstream logic loads words through a start/busy/done handshake.

Parameters:
DATA_BIT, 8, number of data bits per frame (>=1)
OVERSAMPLE, 16, ticks per start bit and per data bit (>=2)
SB_TICK, 16, ticks in the stop period (>=1; 16 = 1 stop bit, 24 = 1.5, 32 = 2)

Ports:
clk  input  1  system clock
rst_n  input  1  reset
tick_i  input  1  one-clk oversampling pulse, driven by the counter max_tick
tx_start_i  input  1  request to send din_i; sampled only in IDLE
din_i  input  DATA_BIT  word to transmit; latched on acceptance
tx_o  output  1  serial line, idle high, registered
busy_o  output  1  high while a frame is in progress (state != IDLE)
tx_done_tick_o  output  1  one-clk pulse at end of frame, registered

Interface: reset rst_n, asynchronous, active-low; clock clk.

Behaviour:
- Reset values: state = IDLE, tick count s = 0, bit index n = 0, shift register b = 0, tx_o = 1, busy_o = 0, tx_done_tick_o = 0.
- Reset mid-frame aborts the frame immediately (asynchronous). tx_o returns high with no done pulse.
- State machine IDLE -> START -> DATA -> STOP -> IDLE. s and n are cleared on entry to every state.
- IDLE:
  - On tx_start_i = 1 at a clk edge: b <= din_i, go to START, tx_o = 0 from that same edge.
  - tx_start_i is ignored in every other state. din_i changes after acceptance have no effect.
- START:
  - tx_o = 0.
  - On each tick_i: if s == OVERSAMPLE-1, go to DATA; else s += 1.
- DATA:
  - tx_o = b[0].
  - On tick_i with s == OVERSAMPLE-1: shift b right by one.
  - If n == DATA_BIT-1 at that point, go to STOP; else n += 1 and s = 0.
- STOP:
  - tx_o = 1.
  - On tick_i with s == SB_TICK-1: go to IDLE and assert tx_done_tick_o for exactly one clk. That clk is the first clk in IDLE.
- Without tick_i, all state, s, n and b hold. Ticks while IDLE are ignored.
- tx_o is a registered copy of the next-state line value and is glitch-free.
- Frame length: (1+DATA_BIT)*OVERSAMPLE + SB_TICK ticks, counted from the acceptance edge to the done edge.
- Back-to-back frames:
  - tx_start_i high during the tx_done_tick_o cycle is accepted, because the block is already in IDLE.
  - tx_o then goes low on that edge, with no extra idle time.
- Counter widths:
  - s is $clog2(max(OVERSAMPLE, SB_TICK)) bits.
  - n is $clog2(DATA_BIT) bits, minimum 1.
  - Comparisons are equality-based, so there is no wrap-around within a state.
- Tick arriving on the acceptance edge: the tick is not counted. Counting starts with the first tick after entry to START.

Test Plan:
1. Basic frame: counter MOD = 4, defaults, din_i = 0xA5, one-clk tx_start_i -> tx_o reads 0 for 16 ticks, then 1,0,1,0,0,1,0,1 at 16 ticks each, then 1 for 16 ticks. tx_done_tick_o pulses once at 160 ticks (640 clk). busy_o is high for exactly those 640 clk.
2. Back-to-back: 0x00 then 0xFF, second tx_start_i asserted in the done cycle -> no idle gap. Line shows start bit, 8 zeros, stop, start bit, 8 ones, stop. Two done pulses 640 clk apart.
3. Ignored start: pulse tx_start_i with din_i = 0x3C mid-frame of a 0x81 transmission -> 0x81 frame is unaffected, no second frame starts, a single done pulse.
4. Reset mid-DATA: assert rst_n low during bit 3 -> tx_o = 1, busy_o = 0 and no done pulse, all asynchronously. A new frame after release transmits correctly.
5. No ticks: hold tick_i = 0 after acceptance for 1000 clk -> tx_o stays 0 and busy_o stays 1. Resuming ticks completes a normal frame.
6. Parameters DATA_BIT = 7, SB_TICK = 32, din_i = 0x55 -> 7 data bits 1,0,1,0,1,0,1. Stop period is 32 ticks. Done pulse at 8*16+32 = 160 ticks.
